multi_serializer: RTL and testbench

Parametrised multi-lane parallel-to-serial converter for the DVI/TMDS output path; successor to the single-lane 10:1 serializer. It takes one flattened word per lane through a valid/ready handshake, buffers it in a one-deep holding register, and shifts all lanes out in lockstep at 1 or 2 bits per clock (SDR, or DDR pairs for an output DDR primitive). When no word is buffered it sends a programmable idle word and flags underflow.

---
 rtl/serializer_pkg.sv | 19 +
 rtl/serializer_lane.sv | 45 ++++
 rtl/multi_serializer.sv | 112 +++++++++++
 tb/tb_multi_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the multi-lane serializer.
package serializer_pkg;

    // TMDS control-period style idle symbol, sent whenever no word is buffered.
    localparam logic [9:0] DEFAULT_IDLE_WORD = 10'b1101010100;

    // Number of clocks needed to shift one lane word out.
    function automatic int phases_of(input int data_w, input int bits_per_clk);
        return data_w / bits_per_clk;
    endfunction

    // Width of the shared phase counter; at least one bit.
    function automatic int cnt_width_of(input int data_w, input int bits_per_clk);
        int phases;
        phases = data_w / bits_per_clk;
        return (phases > 1) ? $clog2(phases) : 1;
    endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: shift register plus output-slice ordering.
// The word is loaded on i_load and then shifted BITS_PER_CLK bits per clock
// toward the output end with zero fill. Slice bit 0 is always the earlier bit.
module serializer_lane
    import serializer_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int BITS_PER_CLK = 1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [DATA_W-1:0]       i_word,
    output logic [BITS_PER_CLK-1:0] o_slice
);

    logic [DATA_W-1:0] r_shift;

    // Load a fresh word on the load edge, otherwise drain toward the output end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
        end else if (MSB_FIRST) begin
            r_shift <= r_shift << BITS_PER_CLK;
        end else begin
            r_shift <= r_shift >> BITS_PER_CLK;
        end
    end

    // Pick the output slice; the bit nearest the output end goes to slice bit 0.
    always_comb begin
        o_slice = '0;
        for (int b = 0; b < BITS_PER_CLK; b++) begin
            if (MSB_FIRST) begin
                o_slice[b] = r_shift[DATA_W-1-b];
            end else begin
                o_slice[b] = r_shift[b];
            end
        end
    end

endmodule

// File: rtl/multi_serializer.sv
// Multi-lane parallel-to-serial converter for the DVI/TMDS output path.
// A one-deep holding register feeds all lanes in lockstep from one phase
// counter. When nothing is held at the load edge every lane sends IDLE_WORD,
// and once the first word has been accepted that event is flagged as a
// sticky underflow.
//
// Handshake: a transfer happens on a rising clk edge where valid_i && ready_o.
// ready_o depends only on the holding register state and the phase counter,
// never on valid_i; data_i is sampled only on the transfer edge. A word taken
// on the load edge waits in the holding register for the following load edge.
module multi_serializer
    import serializer_pkg::*;
#(
    parameter int                CHANNELS     = 4,
    parameter int                DATA_W       = 10,
    parameter int                BITS_PER_CLK = 1,
    parameter bit                MSB_FIRST    = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD    = DEFAULT_IDLE_WORD
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CHANNELS*DATA_W-1:0]       data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [CHANNELS*BITS_PER_CLK-1:0] data_o,
    output logic                             load_o,
    output logic                             underflow_o,
    input  logic                             clear_i
);

    localparam int PHASES = phases_of(DATA_W, BITS_PER_CLK);
    localparam int CNT_W  = cnt_width_of(DATA_W, BITS_PER_CLK);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(PHASES - 1);

    // Reject configurations the lane slicing cannot support.
    generate
        if (!((BITS_PER_CLK == 1 || BITS_PER_CLK == 2) && (DATA_W % BITS_PER_CLK == 0))) begin : g_bad_params
            $error("multi_serializer: BITS_PER_CLK must be 1 or 2 and divide DATA_W");
        end
    endgenerate

    logic [CNT_W-1:0]           r_cnt;
    logic [CHANNELS*DATA_W-1:0] r_hold;
    logic                       r_hold_valid;
    logic                       r_armed;
    logic                       r_underflow;
    logic                       r_load;

    logic w_load_edge;
    logic w_ready;
    logic w_xfer;
    logic w_underflow_set;

    // Control decode: load edge, ready and transfer.
    always_comb begin
        w_load_edge     = (r_cnt == LAST_PHASE);
        w_ready         = !r_hold_valid || w_load_edge;
        w_xfer          = valid_i && w_ready;
        w_underflow_set = w_load_edge && !r_hold_valid && r_armed;
    end

    // Phase counter, holding register, arming and sticky underflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_underflow  <= 1'b0;
            r_load       <= 1'b0;
        end else begin
            r_cnt  <= w_load_edge ? '0 : r_cnt + CNT_W'(1);
            r_load <= w_load_edge;
            if (w_xfer) begin
                r_hold       <= data_i;
                r_hold_valid <= 1'b1;
                r_armed      <= 1'b1;
            end else if (w_load_edge) begin
                r_hold_valid <= 1'b0;
            end
            // A new underflow takes priority over a simultaneous clear.
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end else if (clear_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // One lane per channel; all share the load strobe from the phase counter.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [DATA_W-1:0] w_word;
        assign w_word = r_hold_valid ? r_hold[c*DATA_W +: DATA_W] : IDLE_WORD;

        serializer_lane #(
            .DATA_W       (DATA_W),
            .BITS_PER_CLK (BITS_PER_CLK),
            .MSB_FIRST    (MSB_FIRST)
        ) u_lane (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_load  (w_load_edge),
            .i_word  (w_word),
            .o_slice (data_o[c*BITS_PER_CLK +: BITS_PER_CLK])
        );
    end

    assign ready_o     = w_ready;
    assign load_o      = r_load;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_multi_serializer.sv
// Directed and randomised bench for multi_serializer.
// u_dut1 uses the defaults (SDR, LSB first); u_dut2 runs DDR, MSB first.
// Everything is checked and driven on the falling edge; cycle 0 is the
// first cycle after the reset edge.
module tb_multi_serializer;

    localparam int CH   = 4;
    localparam int DW   = 10;
    localparam int W    = CH * DW;
    localparam int NCYC = 10000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] idle_w = 10'b1101010100;

    // DUT 1: defaults
    logic [W-1:0]      data1 = '0;
    logic              valid1 = 1'b0;
    logic              clear1 = 1'b0;
    logic              ready1;
    logic [CH-1:0]     dout1;
    logic              load1;
    logic              uf1;

    // DUT 2: DDR, MSB first
    logic [W-1:0]      data2 = '0;
    logic              valid2 = 1'b0;
    logic              clear2 = 1'b0;
    logic              ready2;
    logic [CH*2-1:0]   dout2;
    logic              load2;
    logic              uf2;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: accepted words in order, and the kind of each load (1 = data)
    logic [W-1:0] exp_q[$];
    bit           kind_q[$];

    multi_serializer u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data1),
        .valid_i     (valid1),
        .ready_o     (ready1),
        .data_o      (dout1),
        .load_o      (load1),
        .underflow_o (uf1),
        .clear_i     (clear1)
    );

    multi_serializer #(
        .BITS_PER_CLK (2),
        .MSB_FIRST    (1'b1)
    ) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data2),
        .valid_i     (valid2),
        .ready_o     (ready2),
        .data_o      (dout2),
        .load_o      (load2),
        .underflow_o (uf2),
        .clear_i     (clear2)
    );

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        valid1 = 1'b0;
        valid2 = 1'b0;
        clear1 = 1'b0;
        clear2 = 1'b0;
        data1  = '0;
        data2  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (dout1 !== '0)   begin n_fail++; $display("FAIL reset_data1 got %h expected 0", dout1); end
        n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1 got %b expected 1", ready1); end
        n_checks++; if (load1 !== 1'b0)  begin n_fail++; $display("FAIL reset_load1 got %b expected 0", load1); end
        n_checks++; if (uf1 !== 1'b0)    begin n_fail++; $display("FAIL reset_uf1 got %b expected 0", uf1); end
        n_checks++; if (dout2 !== '0)   begin n_fail++; $display("FAIL reset_data2 got %h expected 0", dout2); end
        n_checks++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_ready2 got %b expected 1", ready2); end
    endtask

    task automatic test_idle();
        logic [CH-1:0] exp_d;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            exp_d = (k < 10) ? '0 : {CH{idle_w[(k-10)%10]}};
            n_checks++; if (dout1 !== exp_d) begin n_fail++; $display("FAIL idle_data k=%0d got %h expected %h", k, dout1, exp_d); end
            n_checks++; if (load1 !== (k >= 10 && k % 10 == 0)) begin n_fail++; $display("FAIL idle_load k=%0d got %b", k, load1); end
            n_checks++; if (uf1 !== 1'b0) begin n_fail++; $display("FAIL idle_uf k=%0d got %b expected 0", k, uf1); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words[3];
        logic [CH-1:0] exp_d;
        logic [DW-1:0] w;
        bit            exp_rdy;
        int            idx;
        words[0] = 10'h3FF;
        words[1] = 10'h000;
        words[2] = 10'h155;
        idx = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k < 10) begin
                exp_d = '0;
            end else begin
                w     = words[(k-10)/10];
                exp_d = {CH{w[(k-10)%10]}};
            end
            exp_rdy = (k == 0) || (k % 10 == 9) || (k >= 30);
            n_checks++; if (dout1 !== exp_d) begin n_fail++; $display("FAIL b2b_data k=%0d got %h expected %h", k, dout1, exp_d); end
            n_checks++; if (ready1 !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready k=%0d got %b expected %b", k, ready1, exp_rdy); end
            n_checks++; if (load1 !== (k >= 10 && k % 10 == 0)) begin n_fail++; $display("FAIL b2b_load k=%0d got %b", k, load1); end
            n_checks++; if (uf1 !== 1'b0) begin n_fail++; $display("FAIL b2b_uf k=%0d got %b expected 0", k, uf1); end
            if (idx < 3) begin
                valid1 = 1'b1;
                data1  = {CH{words[idx]}};
            end else begin
                valid1 = 1'b0;
            end
            if (valid1 && exp_rdy) idx++;
            @(negedge clk);
        end
        valid1 = 1'b0;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] w2aa;
        logic [CH-1:0] exp_d;
        bit            exp_uf;
        w2aa = 10'h2AA;
        do_reset();
        for (int k = 0; k < 35; k++) begin
            if (k < 10)      exp_d = '0;
            else if (k < 20) exp_d = {CH{w2aa[k-10]}};
            else             exp_d = {CH{idle_w[(k-20)%10]}};
            exp_uf = (k >= 20 && k <= 22) || (k >= 30);
            n_checks++; if (dout1 !== exp_d) begin n_fail++; $display("FAIL uf_data k=%0d got %h expected %h", k, dout1, exp_d); end
            n_checks++; if (uf1 !== exp_uf) begin n_fail++; $display("FAIL uf_flag k=%0d got %b expected %b", k, uf1, exp_uf); end
            n_checks++; if (load1 !== (k >= 10 && k % 10 == 0)) begin n_fail++; $display("FAIL uf_load k=%0d got %b", k, load1); end
            valid1 = (k == 0);
            data1  = {CH{w2aa}};
            clear1 = (k == 22) || (k == 29);
            @(negedge clk);
        end
        valid1 = 1'b0;
        clear1 = 1'b0;
    endtask

    task automatic test_ddr_msb();
        logic [1:0]      tbl[5];
        logic [CH*2-1:0] exp_d;
        bit              exp_rdy;
        int              p;
        tbl[0] = 2'b01;
        tbl[1] = 2'b00;
        tbl[2] = 2'b00;
        tbl[3] = 2'b00;
        tbl[4] = 2'b10;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k < 5) begin
                exp_d = '0;
            end else if (k < 10) begin
                exp_d = {CH{tbl[k-5]}};
            end else begin
                p     = (k - 10) % 5;
                exp_d = {CH{idle_w[8-2*p], idle_w[9-2*p]}};
            end
            exp_rdy = (k == 0) || (k >= 4);
            n_checks++; if (dout2 !== exp_d) begin n_fail++; $display("FAIL ddr_data k=%0d got %h expected %h", k, dout2, exp_d); end
            n_checks++; if (load2 !== (k >= 5 && k % 5 == 0)) begin n_fail++; $display("FAIL ddr_load k=%0d got %b", k, load2); end
            n_checks++; if (ready2 !== exp_rdy) begin n_fail++; $display("FAIL ddr_ready k=%0d got %b expected %b", k, ready2, exp_rdy); end
            n_checks++; if (uf2 !== (k >= 10)) begin n_fail++; $display("FAIL ddr_uf k=%0d got %b", k, uf2); end
            valid2 = (k == 0);
            data2  = {CH{10'b1000000001}};
            @(negedge clk);
        end
        valid2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
        logic [CH-1:0] exp_d;
        bit            exp_rdy;
        bit            exp_ld;
        int            j;
        wa = 10'h0F0;
        wb = 10'h30C;
        do_reset();
        for (int k = 0; k < 45; k++) begin
            if (k < 15) begin
                exp_d   = (k < 10) ? '0 : {CH{wa[k-10]}};
                exp_rdy = (k == 0) || (k == 9) || (k == 10);
                exp_ld  = (k == 10);
            end else begin
                j       = k - 15;
                exp_d   = (j < 10) ? '0 : {CH{idle_w[(j-10)%10]}};
                exp_rdy = 1'b1;
                exp_ld  = (j >= 10 && j % 10 == 0);
            end
            n_checks++; if (dout1 !== exp_d) begin n_fail++; $display("FAIL rmid_data k=%0d got %h expected %h", k, dout1, exp_d); end
            n_checks++; if (ready1 !== exp_rdy) begin n_fail++; $display("FAIL rmid_ready k=%0d got %b expected %b", k, ready1, exp_rdy); end
            n_checks++; if (load1 !== exp_ld) begin n_fail++; $display("FAIL rmid_load k=%0d got %b expected %b", k, load1, exp_ld); end
            n_checks++; if (uf1 !== 1'b0) begin n_fail++; $display("FAIL rmid_uf k=%0d got %b expected 0", k, uf1); end
            valid1 = (k == 0) || (k == 10);
            data1  = (k == 0) ? {CH{wa}} : {CH{wb}};
            rst    = (k == 14);
            @(negedge clk);
        end
        valid1 = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_random();
        int           m_cnt;
        bit           m_hv, m_armed, m_uf, m_load;
        bit           exp_rdy, xfer, ld_edge, stay, col, kind;
        int           ph, rate;
        logic [W-1:0] rx, exp_w;
        m_cnt = 0; m_hv = 0; m_armed = 0; m_uf = 0; m_load = 0;
        stay = 0; col = 0; ph = 0; rx = '0;
        exp_q.delete();
        kind_q.delete();
        do_reset();
        for (int k = 0; k < NCYC + 30; k++) begin
            exp_rdy = !m_hv || (m_cnt == 9);
            n_checks++; if (ready1 !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready k=%0d got %b expected %b", k, ready1, exp_rdy); end
            n_checks++; if (load1 !== m_load) begin n_fail++; $display("FAIL rnd_load k=%0d got %b expected %b", k, load1, m_load); end
            n_checks++; if (uf1 !== m_uf) begin n_fail++; $display("FAIL rnd_uf k=%0d got %b expected %b", k, uf1, m_uf); end
            // reassemble serial bits into lane words
            if (m_load) begin
                col = 1;
                ph  = 0;
            end
            if (col) begin
                for (int c = 0; c < CH; c++) rx[c*DW + ph] = dout1[c];
                ph++;
                if (ph == DW) begin
                    col = 0;
                    n_checks++;
                    if (kind_q.size() == 0) begin
                        n_fail++; $display("FAIL rnd_kind k=%0d no load recorded", k);
                    end else begin
                        kind  = kind_q.pop_front();
                        exp_w = {CH{idle_w}};
                        if (kind) begin
                            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                            else exp_w = 'x;
                        end
                        if (rx !== exp_w) begin n_fail++; $display("FAIL rnd_word k=%0d got %h expected %h", k, rx, exp_w); end
                    end
                end
            end
            // stimulus: keep data stable while a request is pending
            if (!stay) begin
                rate   = ((k / 1000) % 2 == 1) ? 90 : 30;
                valid1 = (k < NCYC) && ($urandom_range(0, 99) < rate);
                for (int c = 0; c < CH; c++) data1[c*DW +: DW] = DW'($urandom_range(0, 1023));
            end
            clear1 = ($urandom_range(0, 15) == 0);
            // model update for the coming edge
            xfer    = valid1 && exp_rdy;
            ld_edge = (m_cnt == 9);
            if (xfer) exp_q.push_back(data1);
            if (ld_edge) kind_q.push_back(m_hv);
            if (ld_edge && !m_hv && m_armed) m_uf = 1;
            else if (clear1) m_uf = 0;
            m_hv    = xfer ? 1'b1 : (ld_edge ? 1'b0 : m_hv);
            m_armed = m_armed | xfer;
            m_load  = ld_edge;
            m_cnt   = ld_edge ? 0 : m_cnt + 1;
            stay    = valid1 && !xfer;
            @(negedge clk);
        end
        valid1 = 1'b0;
        clear1 = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d words left expected 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_underflow();
        test_ddr_msb();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
